// File: rtl/phase_det_gen2.sv
// phase_det_gen2 - second-generation phase detector for the fractional PWM loop.
// Measures the signed clock distance between synchronised rising edges of the
// reference and feedback inputs, wraps it into [-N, N] using a run-time
// half-period N, and tracks lock over consecutive in-tolerance samples.
module phase_det_gen2 #(
   parameter int WIDTH_ERR   = 22,
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH_LCK   = 8
) (
   input  logic                 clk,
   input  logic                 sync_rst_n,
   input  logic                 enable,
   input  logic                 ref_phase,
   input  logic                 fb_phase,
   input  logic [WIDTH_ERR-2:0] half_period,
   input  logic [WIDTH_ERR-2:0] lock_tol,
   input  logic [WIDTH_LCK-1:0] lock_count,
   output logic [WIDTH_ERR-1:0] err,
   output logic                 err_valid,
   output logic                 pd_error,
   output logic                 miss_ref,
   output logic                 miss_fb,
   output logic                 timeout,
   output logic                 lock
);

   // Fewer than two synchroniser flops would not protect against metastability.
   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   localparam logic [WIDTH_ERR-2:0] TIMER_ONE = {{(WIDTH_ERR-2){1'b0}}, 1'b1};
   localparam logic [WIDTH_ERR:0]   EXT_TWO   = {{(WIDTH_ERR-1){1'b0}}, 2'b10};
   localparam logic [WIDTH_LCK-1:0] LCK_ONE   = {{(WIDTH_LCK-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      LEAD_REF,
      LEAD_FB
   } state_t;

   state_t state, state_next;

   logic [SYNC_N-1:0]      ref_sync, fb_sync;
   logic                   ref_prev, fb_prev;
   logic                   re, fe;

   logic [WIDTH_ERR-2:0]   timer, timer_next;
   logic [WIDTH_ERR-2:0]   n_lat, n_next;
   logic [WIDTH_ERR:0]     timer_ext;
   logic                   tmo_hit;
   logic                   timeout_next;

   logic                   sample_valid;
   logic signed [WIDTH_ERR:0] sample_raw;
   logic [WIDTH_ERR-2:0]   sample_n;

   logic                   s1_valid;
   logic signed [WIDTH_ERR:0] s1_raw;
   logic [WIDTH_ERR-2:0]   s1_n;
   logic signed [WIDTH_ERR:0] n_ext, two_n, wrapped;

   logic                   s2_valid;
   logic signed [WIDTH_ERR:0] s2_val;
   logic [WIDTH_ERR:0]     s2_abs;
   logic                   in_tol;

   logic [WIDTH_LCK-1:0]   lock_cnt, cnt_inc;
   logic                   lock_clear;

   // Bring both asynchronous inputs into the clock domain and remember the last synchronised level.
   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         ref_sync <= '0;
         fb_sync  <= '0;
         ref_prev <= 1'b0;
         fb_prev  <= 1'b0;
      end else begin
         ref_sync <= {ref_sync[SYNC_N-2:0], ref_phase};
         fb_sync  <= {fb_sync[SYNC_N-2:0], fb_phase};
         ref_prev <= ref_sync[SYNC_N-1];
         fb_prev  <= fb_sync[SYNC_N-1];
      end
   end

   assign re = ref_sync[SYNC_N-1] & ~ref_prev;
   assign fe = fb_sync[SYNC_N-1] & ~fb_prev;

   assign timer_ext = {2'b00, timer};
   // Abort when the next count would reach 2N-1; all-ones guards against timer wrap for oversized N.
   assign tmo_hit   = ((timer_ext + EXT_TWO) == {1'b0, n_lat, 1'b0}) || (&timer);

   // Measurement state register, running timer, latched half-period and registered timeout pulse.
   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         state   <= IDLE;
         timer   <= '0;
         n_lat   <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= state_next;
         timer   <= timer_next;
         n_lat   <= n_next;
         timeout <= timeout_next;
      end
   end

   // Next-state logic: start, terminate, restart or abort a measurement; miss pulses coincide with the repeated edge.
   always_comb begin
      state_next   = state;
      timer_next   = timer;
      n_next       = n_lat;
      timeout_next = 1'b0;
      miss_ref     = 1'b0;
      miss_fb      = 1'b0;
      sample_valid = 1'b0;
      sample_raw   = '0;
      sample_n     = n_lat;
      if (!enable) begin
         state_next = IDLE;
         timer_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (half_period > TIMER_ONE) begin
                  if (re && fe) begin
                     sample_valid = 1'b1;
                     sample_n     = half_period;
                  end else if (re) begin
                     state_next = LEAD_REF;
                     timer_next = TIMER_ONE;
                     n_next     = half_period;
                  end else if (fe) begin
                     state_next = LEAD_FB;
                     timer_next = TIMER_ONE;
                     n_next     = half_period;
                  end
               end
            end
            LEAD_REF: begin
               if (fe) begin
                  sample_valid = 1'b1;
                  sample_raw   = -$signed(timer_ext);
                  state_next   = IDLE;
                  timer_next   = '0;
               end else if (re) begin
                  miss_fb    = 1'b1;
                  timer_next = TIMER_ONE;
               end else if (tmo_hit) begin
                  timeout_next = 1'b1;
                  state_next   = IDLE;
                  timer_next   = '0;
               end else begin
                  timer_next = timer + TIMER_ONE;
               end
            end
            LEAD_FB: begin
               if (re) begin
                  sample_valid = 1'b1;
                  sample_raw   = $signed(timer_ext);
                  state_next   = IDLE;
                  timer_next   = '0;
               end else if (fe) begin
                  miss_ref   = 1'b1;
                  timer_next = TIMER_ONE;
               end else if (tmo_hit) begin
                  timeout_next = 1'b1;
                  state_next   = IDLE;
                  timer_next   = '0;
               end else begin
                  timer_next = timer + TIMER_ONE;
               end
            end
            default: begin
               state_next = IDLE;
               timer_next = '0;
            end
         endcase
      end
   end

   assign pd_error = (state != IDLE);

   // Wrap the registered raw distance into [-N, N] using the N that was active for that measurement.
   always_comb begin
      n_ext = $signed({2'b00, s1_n});
      two_n = $signed({1'b0, s1_n, 1'b0});
      if (s1_raw > n_ext) begin
         wrapped = s1_raw - two_n;
      end else if (s1_raw < -n_ext) begin
         wrapped = s1_raw + two_n;
      end else begin
         wrapped = s1_raw;
      end
   end

   // Three-stage result pipeline: raw capture, wrap, output; keeps running regardless of enable.
   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         s1_valid  <= 1'b0;
         s1_raw    <= '0;
         s1_n      <= '0;
         s2_valid  <= 1'b0;
         s2_val    <= '0;
         err       <= '0;
         err_valid <= 1'b0;
      end else begin
         s1_valid  <= sample_valid;
         s1_raw    <= sample_raw;
         s1_n      <= sample_n;
         s2_valid  <= s1_valid;
         s2_val    <= wrapped;
         err_valid <= s2_valid;
         if (s2_valid) begin
            err <= s2_val[WIDTH_ERR-1:0];
         end
      end
   end

   // Magnitude test and saturating increment for the sample about to be presented on err.
   always_comb begin
      s2_abs     = s2_val[WIDTH_ERR] ? $unsigned(-s2_val) : $unsigned(s2_val);
      in_tol     = (s2_abs <= {2'b00, lock_tol});
      cnt_inc    = (&lock_cnt) ? lock_cnt : lock_cnt + LCK_ONE;
      lock_clear = !enable || timeout || miss_ref || miss_fb;
   end

   // Lock tracker updates together with err so lock reflects the sample shown on err_valid.
   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         lock_cnt <= '0;
         lock     <= 1'b0;
      end else if (lock_clear) begin
         lock_cnt <= '0;
         lock     <= 1'b0;
      end else if (s2_valid) begin
         if (in_tol) begin
            lock_cnt <= cnt_inc;
            lock     <= (cnt_inc >= lock_count);
         end else begin
            lock_cnt <= '0;
            lock     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_phase_det_gen2.sv
// tb_phase_det_gen2 - directed self-checking bench for phase_det_gen2.
// An input rising at bench cycle c produces its internal edge pulse at c+2;
// a terminating edge at cycle T shows err_valid at T+3.
module tb_phase_det_gen2;

   localparam int WIDTH_ERR = 22;
   localparam int WIDTH_LCK = 8;

   logic                 clk = 1'b0;
   logic                 sync_rst_n;
   logic                 enable;
   logic                 ref_phase;
   logic                 fb_phase;
   logic [WIDTH_ERR-2:0] half_period;
   logic [WIDTH_ERR-2:0] lock_tol;
   logic [WIDTH_LCK-1:0] lock_count;
   logic [WIDTH_ERR-1:0] err;
   logic                 err_valid;
   logic                 pd_error;
   logic                 miss_ref;
   logic                 miss_fb;
   logic                 timeout;
   logic                 lock;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   int ev_cnt = 0, ev_cyc = 0, ev_err = 0, ev_lock = 0;
   int to_cnt = 0, to_cyc = 0;
   int mf_cnt = 0, mf_cyc = 0;
   int mr_cnt = 0, mr_cyc = 0;
   int pd_cnt = 0;

   int last_ref_cyc = 0;
   int last_fb_cyc  = 0;
   int ev_base, pd_base, to_base, mf_base, mr_base;

   phase_det_gen2 #(
      .WIDTH_ERR  (WIDTH_ERR),
      .SYNC_STAGES(2),
      .WIDTH_LCK  (WIDTH_LCK)
   ) dut (
      .clk        (clk),
      .sync_rst_n (sync_rst_n),
      .enable     (enable),
      .ref_phase  (ref_phase),
      .fb_phase   (fb_phase),
      .half_period(half_period),
      .lock_tol   (lock_tol),
      .lock_count (lock_count),
      .err        (err),
      .err_valid  (err_valid),
      .pd_error   (pd_error),
      .miss_ref   (miss_ref),
      .miss_fb    (miss_fb),
      .timeout    (timeout),
      .lock       (lock)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record output events at the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (err_valid === 1'b1) begin
         ev_cnt  <= ev_cnt + 1;
         ev_cyc  <= cyc;
         ev_err  <= $signed(err);
         ev_lock <= int'(lock);
      end
      if (timeout === 1'b1) begin
         to_cnt <= to_cnt + 1;
         to_cyc <= cyc;
      end
      if (miss_fb === 1'b1) begin
         mf_cnt <= mf_cnt + 1;
         mf_cyc <= cyc;
      end
      if (miss_ref === 1'b1) begin
         mr_cnt <= mr_cnt + 1;
         mr_cyc <= cyc;
      end
      if (pd_error === 1'b1) begin
         pd_cnt <= pd_cnt + 1;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raise the selected inputs at the current falling edge, hold two cycles, release.
   task automatic applyStimulus(input logic do_ref, input logic do_fb);
      if (do_ref) begin
         ref_phase    = 1'b1;
         last_ref_cyc = cyc;
      end
      if (do_fb) begin
         fb_phase    = 1'b1;
         last_fb_cyc = cyc;
      end
      repeat (2) @(negedge clk);
      ref_phase = 1'b0;
      fb_phase  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      sync_rst_n  = 1'b0;
      enable      = 1'b1;
      ref_phase   = 1'b0;
      fb_phase    = 1'b0;
      half_period = 21'd1000;
      lock_tol    = 21'd5;
      lock_count  = 8'd4;
      waitCycles(3);
      checkOutput("reset_outputs",
                  int'({err, err_valid, pd_error, miss_ref, miss_fb, timeout, lock}), 0);
      sync_rst_n = 1'b1;
      waitCycles(4);

      // Reference leads feedback by 37 cycles.
      ev_base = ev_cnt;
      pd_base = pd_cnt;
      applyStimulus(1'b1, 1'b0);
      waitCycles(35);
      applyStimulus(1'b0, 1'b1);
      waitCycles(12);
      checkOutput("lead_ref_count", ev_cnt - ev_base, 1);
      checkOutput("lead_ref_err", ev_err, -37);
      checkOutput("lead_ref_latency", ev_cyc, last_fb_cyc + 5);
      checkOutput("lead_ref_pd_cycles", pd_cnt - pd_base, 37);
      checkOutput("lead_ref_lock", ev_lock, 0);

      // Feedback leads by 1500 (wraps to -500), then by 999 (no wrap).
      applyStimulus(1'b0, 1'b1);
      waitCycles(1498);
      applyStimulus(1'b1, 1'b0);
      waitCycles(12);
      checkOutput("wrap_1500_err", ev_err, -500);
      checkOutput("wrap_1500_latency", ev_cyc, last_ref_cyc + 5);
      applyStimulus(1'b0, 1'b1);
      waitCycles(997);
      applyStimulus(1'b1, 1'b0);
      waitCycles(12);
      checkOutput("lead_fb_999_err", ev_err, 999);

      // Coincident edges from IDLE give a single zero sample.
      ev_base = ev_cnt;
      applyStimulus(1'b1, 1'b1);
      waitCycles(12);
      checkOutput("coincident_count", ev_cnt - ev_base, 1);
      checkOutput("coincident_err", ev_err, 0);
      checkOutput("coincident_latency", ev_cyc, last_ref_cyc + 5);

      // N=1: every starting edge is ignored.
      half_period = 21'd1;
      waitCycles(2);
      ev_base = ev_cnt;
      pd_base = pd_cnt;
      applyStimulus(1'b1, 1'b1);
      waitCycles(10);
      applyStimulus(1'b1, 1'b0);
      waitCycles(10);
      checkOutput("n1_no_valid", ev_cnt - ev_base, 0);
      checkOutput("n1_no_measure", pd_cnt - pd_base, 0);

      // N=100: lone reference edge times out 2N-1 cycles after the edge.
      half_period = 21'd100;
      waitCycles(2);
      ev_base = ev_cnt;
      pd_base = pd_cnt;
      to_base = to_cnt;
      applyStimulus(1'b1, 1'b0);
      waitCycles(220);
      checkOutput("timeout_count", to_cnt - to_base, 1);
      checkOutput("timeout_cycle", to_cyc, last_ref_cyc + 2 + 199);
      checkOutput("timeout_no_valid", ev_cnt - ev_base, 0);
      checkOutput("timeout_pd_cycles", pd_cnt - pd_base, 198);
      checkOutput("timeout_idle", int'(pd_error), 0);

      // Repeated reference edge restarts the measurement and flags miss_fb.
      half_period = 21'd1000;
      waitCycles(2);
      mf_base = mf_cnt;
      applyStimulus(1'b1, 1'b0);
      waitCycles(48);
      applyStimulus(1'b1, 1'b0);
      waitCycles(18);
      applyStimulus(1'b0, 1'b1);
      waitCycles(12);
      checkOutput("miss_fb_count", mf_cnt - mf_base, 1);
      checkOutput("miss_fb_cycle", mf_cyc, last_ref_cyc + 2);
      checkOutput("miss_fb_err", ev_err, -20);
      checkOutput("miss_fb_latency", ev_cyc, last_fb_cyc + 5);

      // Repeated feedback edge flags miss_ref.
      mr_base = mr_cnt;
      applyStimulus(1'b0, 1'b1);
      waitCycles(28);
      applyStimulus(1'b0, 1'b1);
      waitCycles(8);
      applyStimulus(1'b1, 1'b0);
      waitCycles(12);
      checkOutput("miss_ref_count", mr_cnt - mr_base, 1);
      checkOutput("miss_ref_cycle", mr_cyc, last_fb_cyc + 2);
      checkOutput("miss_ref_err", ev_err, 10);

      // Lock: -3, +2, 0, +4 in tolerance, then +9 breaks lock.
      applyStimulus(1'b1, 1'b0);
      waitCycles(1);
      applyStimulus(1'b0, 1'b1);
      waitCycles(12);
      checkOutput("lock_s1_err", ev_err, -3);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0);
      waitCycles(12);
      checkOutput("lock_s2_err", ev_err, 2);
      applyStimulus(1'b1, 1'b1);
      waitCycles(12);
      checkOutput("lock_s3_lock", ev_lock, 0);
      applyStimulus(1'b0, 1'b1);
      waitCycles(2);
      applyStimulus(1'b1, 1'b0);
      waitCycles(12);
      checkOutput("lock_s4_err", ev_err, 4);
      checkOutput("lock_s4_lock", ev_lock, 1);
      applyStimulus(1'b0, 1'b1);
      waitCycles(7);
      applyStimulus(1'b1, 1'b0);
      waitCycles(12);
      checkOutput("lock_s5_err", ev_err, 9);
      checkOutput("lock_s5_lock", ev_lock, 0);

      // enable=0 aborts a measurement and blocks new ones.
      applyStimulus(1'b1, 1'b0);
      waitCycles(5);
      checkOutput("enable_pd_before", int'(pd_error), 1);
      enable = 1'b0;
      waitCycles(2);
      checkOutput("enable_pd_after", int'(pd_error), 0);
      ev_base = ev_cnt;
      pd_base = pd_cnt;
      applyStimulus(1'b0, 1'b1);
      waitCycles(10);
      checkOutput("enable_no_valid", ev_cnt - ev_base, 0);
      checkOutput("enable_no_measure", pd_cnt - pd_base, 0);
      enable = 1'b1;
      waitCycles(4);

      // Reach lock with four zero samples, then reset mid-measurement.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1);
         waitCycles(8);
      end
      checkOutput("prereset_lock", int'(lock), 1);
      applyStimulus(1'b1, 1'b0);
      waitCycles(5);
      checkOutput("prereset_pd", int'(pd_error), 1);
      ev_base = ev_cnt;
      sync_rst_n = 1'b0;
      #1;
      checkOutput("midreset_outputs",
                  int'({err, err_valid, pd_error, miss_ref, miss_fb, timeout, lock}), 0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1);
      waitCycles(2);
      sync_rst_n = 1'b1;
      waitCycles(10);
      checkOutput("postreset_no_valid", ev_cnt - ev_base, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/phase_det_gen2.md
Name: phase_det_gen2

Overview:
Parametrised second-generation phase detector for the fractional PWM loop.
- Measures the signed clock-count distance between synchronised rising edges of a reference input and a feedback input.
- Wraps the result modulo ±half_period, which is programmable at run time instead of fixed at build time.
- Adds a timeout, missed-edge flags and a lock indicator.
- Feeds the loop filter through a one-cycle err_valid strobe.

Parameters:
WIDTH_ERR, 22, width of signed err output; timer and half_period are WIDTH_ERR-1 bits.
SYNC_STAGES, 2, flops in each input synchroniser (minimum 2).
WIDTH_LCK, 8, width of lock_count and the internal lock counter.

Ports:
clk  in  1  system clock
sync_rst_n  in  1  reset, asynchronous assert, active-low
enable  in  1  1 = measure; 0 = force IDLE, clear lock
ref_phase  in  1  reference phase input, asynchronous
fb_phase  in  1  feedback phase input, asynchronous
half_period  in  WIDTH_ERR-1  modulus N in clocks (half a reference period)
lock_tol  in  WIDTH_ERR-1  lock tolerance on |err|
lock_count  in  WIDTH_LCK  consecutive in-tolerance samples required for lock
err  out  WIDTH_ERR  signed phase error, held between samples
err_valid  out  1  one-cycle strobe, err updated this cycle
pd_error  out  1  measurement in progress (state LEAD_REF or LEAD_FB)
miss_ref  out  1  one-cycle pulse, feedback edge repeated before a reference edge
miss_fb  out  1  one-cycle pulse, reference edge repeated before a feedback edge
timeout  out  1  one-cycle pulse, measurement aborted
lock  out  1  loop locked

Behaviour:
- Reset (sync_rst_n=0, asynchronous): state IDLE, timer=0, all pipeline stages cleared, lock counter=0. All outputs 0.
- Input conditioning: each input passes through SYNC_STAGES flops and then a rising-edge detector. re and fe are one-cycle pulses; all timing below is referenced to these pulses.
- N handling:
  - N is latched when a measurement starts.
  - If N<2, starting edges are ignored and the block stays in IDLE.
- FSM states: IDLE, LEAD_REF, LEAD_FB.
- From IDLE:
  - re and fe in the same cycle: zero result (raw=0) enters the pipeline; stay IDLE.
  - re alone: go to LEAD_REF, timer=1.
  - fe alone: go to LEAD_FB, timer=1.
- In LEAD_REF (and LEAD_FB symmetrically), the timer increments every cycle.
  - fe in LEAD_REF: raw = -timer, go to IDLE. Reference leading gives a negative error.
  - re in LEAD_FB: raw = +timer, go to IDLE.
  - A terminating edge arriving k cycles after the starting edge gives |raw|=k.
  - re again in LEAD_REF (no fe): pulse miss_fb, timer=1, stay in LEAD_REF, no sample. Symmetric case (fe again in LEAD_FB) pulses miss_ref.
  - Both re and fe in the same cycle in a LEAD state: the terminating edge wins. Result is produced, then go to IDLE; the other edge is dropped.
  - timer reaches 2N-1 with no terminating edge: pulse timeout, go to IDLE, no sample.
- enable=0:
  - Same cycle: go to IDLE, timer=0, lock=0, lock counter=0.
  - Results already in the pipeline still complete.
  - No new measurements start while enable=0.
- Pipeline; terminating edge at cycle T:
  - T+1: raw registered, signed WIDTH_ERR+1 bits.
  - T+2: wrap. If raw > N, raw-2N; else if raw < -N, raw+2N; else raw unchanged. The result lies in [-N, N] and always fits WIDTH_ERR, so no saturation logic.
  - T+3: err updated, err_valid=1 for one cycle.
  - Back-to-back results are fully pipelined with no stall.
- Lock, evaluated on each err_valid:
  - |err| ≤ lock_tol: counter increments, saturating at all-ones.
  - |err| > lock_tol: counter=0, lock=0.
  - lock=1 when counter ≥ lock_count.
  - lock_count=0 means lock follows the first in-tolerance sample.
  - Any timeout, miss_ref or miss_fb pulse: counter=0 and lock=0 on the next cycle.
- Reset mid-measurement: everything clears immediately and no err_valid is produced.

Test Plan:
- N=1000. re at t0, fe 37 cycles later → err_valid 3 cycles after fe, err=-37, pd_error high for 37 cycles.
- N=1000. fe then re 1500 cycles later → raw +1500 wraps to err=-500. Also fe then re 999 cycles later → err=+999.
- re and fe same cycle from IDLE → err=0, err_valid once. Repeat with N=1 → no err_valid ever.
- N=100. re with no fe → timeout pulse exactly 199 cycles after re, no err_valid, state IDLE.
- re, re 50 cycles later, then fe 20 cycles after that → miss_fb pulse at the second re, then err=-20.
- lock_tol=5, lock_count=4. Samples -3,+2,0,+4 → lock=1 on the 4th err_valid. Next sample +9 → lock=0. Drive sync_rst_n low mid-measurement → all outputs 0 at once.
